// File: rtl/obstacle_collide_if.sv
// Bus between the obstacle/collision block and its neighbours: frame strobe,
// game control and player height in; obstacle position, score and flags out.
interface obstacle_collide_if;
    logic       tick;
    logic       start;
    logic [9:0] player_h;
    logic [9:0] obs_x;
    logic [7:0] score;
    logic       hit;
    logic       win;
    logic       fall_en;

    modport master (
        output tick, start, player_h,
        input  obs_x, score, hit, win, fall_en
    );

    modport slave (
        input  tick, start, player_h,
        output obs_x, score, hit, win, fall_en
    );
endinterface

// File: rtl/obstacle_collide.sv
// Scrolls one obstacle across the screen, tests it against the player square
// every frame tick, counts cleared obstacles and reports HIT or WIN.
module obstacle_collide #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned OBS_W      = 20,
    parameter int unsigned OBS_H      = 40,
    parameter int unsigned PLAYER_X   = 100,
    parameter int unsigned PLAYER_W   = 20,
    parameter int unsigned STEP       = 4,
    parameter int unsigned WIN_SCORE  = 10,
    parameter int unsigned FALL_TICKS = 12
) (
    input logic                clk,
    input logic                reset,
    obstacle_collide_if.slave  bus
);
    localparam int unsigned XW = 10;
    localparam int unsigned SW = 8;
    localparam int unsigned CW = $clog2(FALL_TICKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, HIT, WIN} state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] obs_x, obs_x_nxt;
    logic [SW-1:0] score, score_nxt;
    logic [CW-1:0] fall_cnt, fall_cnt_nxt;
    logic          fall_en, fall_en_nxt;
    logic          hit, hit_nxt;
    logic          win, win_nxt;
    logic          overlap_c;

    // Overlap sums are carried one bit wider than obs_x so nothing wraps.
    always_comb begin
        overlap_c = ({1'b0, obs_x} < (XW+1)'(PLAYER_X + PLAYER_W)) &&
                    (({1'b0, obs_x} + (XW+1)'(OBS_W)) > (XW+1)'(PLAYER_X)) &&
                    (bus.player_h < XW'(OBS_H));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            obs_x    <= XW'(SCREEN_W);
            score    <= '0;
            fall_cnt <= '0;
            fall_en  <= 1'b0;
            hit      <= 1'b0;
            win      <= 1'b0;
        end else begin
            state    <= state_nxt;
            obs_x    <= obs_x_nxt;
            score    <= score_nxt;
            fall_cnt <= fall_cnt_nxt;
            fall_en  <= fall_en_nxt;
            hit      <= hit_nxt;
            win      <= win_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        obs_x_nxt    = obs_x;
        score_nxt    = score;
        fall_cnt_nxt = fall_cnt;
        fall_en_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                obs_x_nxt = XW'(SCREEN_W);
                if (bus.start) begin
                    state_nxt = RUN;
                    score_nxt = '0;
                end
            end
            RUN: begin
                // Collision takes priority over the left-edge wrap.
                if (bus.tick) begin
                    if (overlap_c) begin
                        state_nxt = HIT;
                    end else if (obs_x < XW'(STEP)) begin
                        obs_x_nxt = XW'(SCREEN_W);
                        if (score != {SW{1'b1}}) score_nxt = score + SW'(1);
                        if (({1'b0, score} + (SW+1)'(1)) == (SW+1)'(WIN_SCORE)) begin
                            state_nxt    = WIN;
                            fall_cnt_nxt = '0;
                        end
                    end else begin
                        obs_x_nxt = obs_x - XW'(STEP);
                    end
                end
            end
            HIT: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    obs_x_nxt = XW'(SCREEN_W);
                    score_nxt = '0;
                end
            end
            WIN: begin
                if (bus.start) begin
                    state_nxt    = RUN;
                    obs_x_nxt    = XW'(SCREEN_W);
                    score_nxt    = '0;
                    fall_cnt_nxt = '0;
                end else if (bus.tick && (fall_cnt < CW'(FALL_TICKS))) begin
                    fall_en_nxt  = 1'b1;
                    fall_cnt_nxt = fall_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        hit_nxt = (state_nxt == HIT);
        win_nxt = (state_nxt == WIN);
    end

    assign bus.obs_x   = obs_x;
    assign bus.score   = score;
    assign bus.hit     = hit;
    assign bus.win     = win;
    assign bus.fall_en = fall_en;
endmodule

// File: tb/tb_obstacle_collide.sv
// Directed bench for obstacle_collide; dut_a uses default geometry, dut_b moves
// the player to x=0 so a collision can coincide with the left-edge wrap.
module tb_obstacle_collide;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    obstacle_collide_if a_if ();
    obstacle_collide_if b_if ();

    obstacle_collide dut_a (.clk(clk), .reset(reset), .bus(a_if));
    obstacle_collide #(.PLAYER_X(0)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on negedge; outputs are sampled on the following negedge.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_if.tick = 1'b1;
            b_if.tick = 1'b1;
            @(negedge clk);
            a_if.tick = 1'b0;
            b_if.tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_a();
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_if.tick = 1'b0; a_if.start = 1'b0; a_if.player_h = '0;
        b_if.tick = 1'b0; b_if.start = 1'b0; b_if.player_h = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_obs_x", a_if.obs_x, 640);
        check("rst_score", a_if.score, 0);
        check("rst_hit", a_if.hit, 0);
        check("rst_win", a_if.win, 0);
        check("rst_fall", a_if.fall_en, 0);

        // Player on the ground: scroll until the first overlap at obs_x=116
        start_a();
        check("run_start_x", a_if.obs_x, 640);
        do_ticks(1);
        check("run_first_step", a_if.obs_x, 636);
        do_ticks(130);
        check("run_pre_hit_x", a_if.obs_x, 116);
        check("run_pre_hit", a_if.hit, 0);
        do_ticks(1);
        check("hit_flag", a_if.hit, 1);
        check("hit_frozen_x", a_if.obs_x, 116);
        check("hit_score", a_if.score, 0);
        do_ticks(2);
        check("hit_still_x", a_if.obs_x, 116);

        // Restart from HIT, then start during RUN must be ignored
        start_a();
        check("restart_x", a_if.obs_x, 640);
        check("restart_hit", a_if.hit, 0);
        check("restart_score", a_if.score, 0);
        start_a();
        check("run_start_ign_x", a_if.obs_x, 640);
        do_ticks(1);
        check("run_start_ign_step", a_if.obs_x, 636);

        // Jumping player: ten wraps lead to WIN
        do_reset();
        a_if.player_h = 10'd60;
        start_a();
        do_ticks(160);
        check("wrap_at_zero", a_if.obs_x, 0);
        check("wrap_score0", a_if.score, 0);
        do_ticks(1);
        check("wrap_x", a_if.obs_x, 640);
        check("wrap_score1", a_if.score, 1);
        do_ticks(161 * 8);
        check("score9", a_if.score, 9);
        check("win_pre", a_if.win, 0);
        do_ticks(161);
        check("score10", a_if.score, 10);
        check("win_flag", a_if.win, 1);
        check("win_hit", a_if.hit, 0);
        check("win_no_fall_yet", a_if.fall_en, 0);

        // Exactly FALL_TICKS one-clock pulses, one per tick
        for (int i = 0; i < 16; i++) begin
            do_ticks(1);
            check($sformatf("fall_pulse_%0d", i), a_if.fall_en, (i < 12) ? 1 : 0);
            @(negedge clk);
            check($sformatf("fall_low_%0d", i), a_if.fall_en, 0);
        end
        check("win_hold", a_if.win, 1);

        // Height boundary: 40 clears, 39 collides
        do_reset();
        a_if.player_h = 10'd40;
        start_a();
        do_ticks(160);
        check("h40_no_hit", a_if.hit, 0);
        check("h40_x", a_if.obs_x, 0);
        do_ticks(1);
        a_if.player_h = 10'd39;
        do_ticks(132);
        check("h39_hit", a_if.hit, 1);
        check("h39_x", a_if.obs_x, 116);
        check("h39_score", a_if.score, 1);

        // Collision wins over the left-edge wrap on the same tick
        do_reset();
        b_if.player_h = 10'd60;
        @(negedge clk);
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        do_ticks(160);
        check("prio_pre_x", b_if.obs_x, 0);
        check("prio_pre_hit", b_if.hit, 0);
        b_if.player_h = 10'd0;
        do_ticks(1);
        check("prio_hit", b_if.hit, 1);
        check("prio_x", b_if.obs_x, 0);
        check("prio_score", b_if.score, 0);

        // Reset mid-RUN aborts immediately
        do_reset();
        a_if.player_h = 10'd60;
        start_a();
        do_ticks(161 * 3 + 85);
        check("mid_x", a_if.obs_x, 300);
        check("mid_score", a_if.score, 3);
        do_reset();
        check("mid_rst_x", a_if.obs_x, 640);
        check("mid_rst_score", a_if.score, 0);
        check("mid_rst_hit", a_if.hit, 0);
        check("mid_rst_win", a_if.win, 0);
        check("mid_rst_fall", a_if.fall_en, 0);
        do_ticks(3);
        check("idle_hold_x", a_if.obs_x, 640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
